regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_wb_arbiter_if.sv | 46 ++++
 rtl/wb_hold_slot.sv | 38 +++
 rtl/regfile_wb_arbiter.sv | 129 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register-file write-back path.
package regfile_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 32;
    localparam int unsigned DEF_AW    = $clog2(DEF_DEPTH);

    localparam logic [DEF_AW-1:0] ZERO_ADDR = '0;

    typedef struct packed {
        logic [DEF_AW-1:0]    addr;
        logic [DEF_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Producer handshakes, register-file write port and decode hazard lookup of the write-back arbiter.
interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             alu_valid;
    logic             alu_ready;
    logic [AW-1:0]    alu_addr;
    logic [WIDTH-1:0] alu_data;
    logic             ld_valid;
    logic             ld_ready;
    logic [AW-1:0]    ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic             we;
    logic [AW-1:0]    waddr0;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr0;
    logic [AW-1:0]    raddr1;
    logic             pend0;
    logic             pend1;

    // Producer / decode side.
    modport master (
        output alu_valid, alu_addr, alu_data,
        output ld_valid, ld_addr, ld_data,
        output raddr0, raddr1,
        input  alu_ready, ld_ready,
        input  we, waddr0, wdata,
        input  pend0, pend1
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  ld_valid, ld_addr, ld_data,
        input  raddr0, raddr1,
        output alu_ready, ld_ready,
        output we, waddr0, wdata,
        output pend0, pend1
    );

endinterface

// File: rtl/wb_hold_slot.sv
// Single-entry holding slot; can drain and refill on the same edge.
module wb_hold_slot
    import regfile_pkg::*;
#(
    parameter type entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    input  entry_t in_entry,
    input  logic   drain,
    output logic   ready,
    output logic   held,
    output entry_t entry
);

    logic   held_q;
    entry_t entry_q;

    always_comb begin
        ready = !held_q || drain;
        held  = held_q;
        entry = entry_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q  <= 1'b0;
            entry_q <= '0;
        end else if (in_valid && ready) begin
            held_q  <= 1'b1;
            entry_q <= in_entry;
        end else if (drain) begin
            held_q  <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Age-ordered merge of ALU and load results onto the register file write port,
// with read-after-write pending flags for decode.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter bit          ZERO_REG = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_wb_arbiter_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t alu_in, ld_in, alu_q, ld_q, gnt_entry;
    logic   alu_held, ld_held, alu_rdy, ld_rdy;
    logic   alu_grant, ld_grant, any_grant;
    logic   alu_cap, ld_cap;
    logic   ld_older_q, ld_older_d;

    logic             we_q;
    logic [AW-1:0]    waddr_q;
    logic [WIDTH-1:0] wdata_q;

    always_comb begin
        alu_in = '{addr: bus.alu_addr, data: bus.alu_data};
        ld_in  = '{addr: bus.ld_addr, data: bus.ld_data};
    end

    wb_hold_slot #(
        .entry_t (entry_t)
    ) u_alu_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (bus.alu_valid),
        .in_entry (alu_in),
        .drain    (alu_grant),
        .ready    (alu_rdy),
        .held     (alu_held),
        .entry    (alu_q)
    );

    wb_hold_slot #(
        .entry_t (entry_t)
    ) u_ld_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (bus.ld_valid),
        .in_entry (ld_in),
        .drain    (ld_grant),
        .ready    (ld_rdy),
        .held     (ld_held),
        .entry    (ld_q)
    );

    // Grant looks only at slot state so ready never depends on valid.
    always_comb begin
        alu_grant = alu_held && (!ld_held || !ld_older_q);
        ld_grant  = ld_held && (!alu_held || ld_older_q);
        any_grant = alu_grant || ld_grant;
        gnt_entry = ld_grant ? ld_q : alu_q;
        alu_cap   = bus.alu_valid && alu_rdy;
        ld_cap    = bus.ld_valid && ld_rdy;
    end

    // The slot that stays (or is written first on a tie) is the older one.
    always_comb begin
        ld_older_d = ld_older_q;
        if (alu_cap && ld_cap) begin
            ld_older_d = 1'b1;
        end else if (alu_cap && ld_held) begin
            ld_older_d = 1'b1;
        end else if (ld_cap && alu_held) begin
            ld_older_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_older_q <= 1'b0;
        end else begin
            ld_older_q <= ld_older_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= any_grant && !(ZERO_REG && (gnt_entry.addr == AW'(ZERO_ADDR)));
            if (any_grant) begin
                waddr_q <= gnt_entry.addr;
                wdata_q <= gnt_entry.data;
            end
        end
    end

    function automatic logic pend_hit(input logic [AW-1:0] ra,
                                      input logic a_held, input logic [AW-1:0] a_addr,
                                      input logic l_held, input logic [AW-1:0] l_addr,
                                      input logic w_en, input logic [AW-1:0] w_addr);
        logic hit;
        hit = (a_held && (a_addr == ra)) || (l_held && (l_addr == ra)) ||
              (w_en && (w_addr == ra));
        return hit && !(ZERO_REG && (ra == AW'(ZERO_ADDR)));
    endfunction

    always_comb begin
        bus.alu_ready = alu_rdy;
        bus.ld_ready  = ld_rdy;
        bus.we        = we_q;
        bus.waddr0    = waddr_q;
        bus.wdata     = wdata_q;
        bus.pend0     = pend_hit(bus.raddr0, alu_held, alu_q.addr, ld_held, ld_q.addr,
                                 we_q, waddr_q);
        bus.pend1     = pend_hit(bus.raddr1, alu_held, alu_q.addr, ld_held, ld_q.addr,
                                 we_q, waddr_q);
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised bench for regfile_wb_arbiter against an in-order queue model of accepted writes.
module tb_regfile_wb_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    regfile_wb_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_nz ();

    regfile_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    regfile_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1'b0)) dut_nz (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nz)
    );

    // Accepted writes in age order; src 1 = load, 0 = ALU.
    typedef struct packed {
        logic             src;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } ment_t;

    ment_t            mq[$];
    logic             m_we;
    logic [AW-1:0]    m_waddr;
    logic [WIDTH-1:0] m_wdata;
    logic [WIDTH-1:0] m_rf[DEPTH];
    logic [WIDTH-1:0] d_rf[DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    always @(posedge clk) begin
        if (bus.we) d_rf[bus.waddr0] <= bus.wdata;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_occ(input bit src);
        foreach (mq[i]) if (mq[i].src == src) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ready(input bit src);
        return !m_occ(src) || (mq.size() > 0 && mq[0].src == src);
    endfunction

    function automatic bit m_pend(input logic [AW-1:0] ra);
        if (ra == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].addr == ra) return 1'b1;
        return m_we && (m_waddr == ra);
    endfunction

    task automatic m_reset();
        mq.delete();
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    task automatic drive(input bit av, input logic [AW-1:0] aa, input logic [WIDTH-1:0] ad,
                         input bit lv, input logic [AW-1:0] la, input logic [WIDTH-1:0] ld,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        bus.alu_valid = av;  bus.alu_addr = aa;  bus.alu_data = ad;
        bus.ld_valid  = lv;  bus.ld_addr  = la;  bus.ld_data  = ld;
        bus.raddr0    = r0;  bus.raddr1   = r1;
        bus_nz.alu_valid = av;  bus_nz.alu_addr = aa;  bus_nz.alu_data = ad;
        bus_nz.ld_valid  = lv;  bus_nz.ld_addr  = la;  bus_nz.ld_data  = ld;
        bus_nz.raddr0    = r0;  bus_nz.raddr1   = r1;
    endtask

    // One clock: drive, check ready/pend, take the edge, then check the write port.
    task automatic step(input bit av, input logic [AW-1:0] aa, input logic [WIDTH-1:0] ad,
                        input bit lv, input logic [AW-1:0] la, input logic [WIDTH-1:0] ld,
                        input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        bit    acc_a, acc_l;
        ment_t h;
        drive(av, aa, ad, lv, la, ld, r0, r1);
        #1;
        check_val("alu_ready", bus.alu_ready, m_ready(1'b0));
        check_val("ld_ready", bus.ld_ready, m_ready(1'b1));
        check_val("pend0", bus.pend0, m_pend(r0));
        check_val("pend1", bus.pend1, m_pend(r1));
        acc_a = av && m_ready(1'b0);
        acc_l = lv && m_ready(1'b1);
        @(posedge clk);
        if (m_we) m_rf[m_waddr] = m_wdata;
        if (mq.size() > 0) begin
            h       = mq.pop_front();
            m_we    = (h.addr != 0);
            m_waddr = h.addr;
            m_wdata = h.data;
        end else begin
            m_we = 1'b0;
        end
        if (acc_l) mq.push_back('{src: 1'b1, addr: la, data: ld});
        if (acc_a) mq.push_back('{src: 1'b0, addr: aa, data: ad});
        #1;
        check_val("we", bus.we, m_we);
        check_val("waddr0", bus.waddr0, m_waddr);
        check_val("wdata", bus.wdata, m_wdata);
    endtask

    task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        step(1'b0, '0, '0, 1'b0, '0, '0, r0, r1);
    endtask

    initial begin
        foreach (m_rf[i]) begin
            m_rf[i] = '0;
            d_rf[i] = '0;
        end
        m_reset();
        drive(1'b1, 5'd5, 32'h1, 1'b1, 5'd5, 32'h2, 5'd5, 5'd5);
        #12;
        check_val("rst_we", bus.we, 1'b0);
        check_val("rst_waddr0", bus.waddr0, 0);
        check_val("rst_wdata", bus.wdata, 0);
        check_val("rst_pend0", bus.pend0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU only.
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 5'd5, '0);
        idle(5'd5, '0);
        check_val("alu_only_we", bus.we, 1'b1);
        check_val("alu_only_waddr0", bus.waddr0, 5);
        check_val("alu_only_wdata", bus.wdata, 32'hDEADBEEF);
        idle(5'd5, '0);
        idle(5'd5, '0);

        // Simultaneous capture at the same address: load first.
        step(1'b1, 5'd3, 32'h22, 1'b1, 5'd3, 32'h11, 5'd3, '0);
        idle(5'd3, '0);
        check_val("sim_first_wdata", bus.wdata, 32'h11);
        idle(5'd3, '0);
        check_val("sim_second_wdata", bus.wdata, 32'h22);
        idle('0, '0);

        // Zero register.
        step(1'b1, 5'd0, 32'hFF, 1'b0, '0, '0, 5'd0, '0);
        check_val("nz_pend0", bus_nz.pend0, 1'b1);
        idle(5'd0, '0);
        check_val("zero_we", bus.we, 1'b0);
        check_val("nz_we", bus_nz.we, 1'b1);
        check_val("nz_waddr0", bus_nz.waddr0, 0);
        check_val("nz_wdata", bus_nz.wdata, 32'hFF);
        idle('0, '0);

        // Age ordering on register 7.
        step(1'b0, '0, '0, 1'b1, 5'd7, 32'hAAAA0001, 5'd7, '0);
        step(1'b1, 5'd7, 32'hBBBB0002, 1'b0, '0, '0, 5'd7, '0);
        repeat (3) idle(5'd7, '0);
        check_val("age_rf7", d_rf[7], 32'hBBBB0002);

        // Back-to-back dual-source traffic.
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 5'($urandom_range(1, 15)), $urandom(),
                 1'b1, 5'($urandom_range(1, 15)), $urandom(),
                 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
        end

        // Random traffic with narrow address range to force collisions and zero writes.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom(),
                 1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom(),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        repeat (3) idle('0, '0);

        // Reset mid-flight with both slots held and a write on the port.
        step(1'b1, 5'd9, 32'h9, 1'b1, 5'd10, 32'h10, '0, '0);
        step(1'b1, 5'd11, 32'h11, 1'b1, 5'd12, 32'h12, 5'd9, 5'd12);
        check_val("pre_rst_we", bus.we, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_we", bus.we, 1'b0);
        check_val("mid_rst_waddr0", bus.waddr0, 0);
        check_val("mid_rst_wdata", bus.wdata, 0);
        check_val("mid_rst_pend0", bus.pend0, 1'b0);
        check_val("mid_rst_pend1", bus.pend1, 1'b0);
        m_reset();
        repeat (2) @(posedge clk);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 5'd9, 5'd12);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("post_rst_alu_ready", bus.alu_ready, 1'b1);
        check_val("post_rst_ld_ready", bus.ld_ready, 1'b1);
        @(posedge clk);
        #1;
        repeat (3) idle(5'd9, 5'd12);

        foreach (m_rf[i]) check_val("rf", d_rf[i], m_rf[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
